// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and its width.
package serial_sub_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, bo = borrow out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one fs_cell reused every cycle.
// Optional SERIAL_SUB_OVERFLOW_EN adds a registered signed-overflow flag (ovf).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d, bo, last;

  fs_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bin(br),
    .d  (d),
    .bo (bo)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d, res_sr[WIDTH-1:1]};
          br     <= bo;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff  <= {d, res_sr[WIDTH-1:1]};
            bout  <= bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // On the last bit a_sr[0]/b_sr[0] are the operand MSBs and d is the result MSB
            ovf   <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed vectors plus a WIDTH=4 exhaustive sweep.
// Checks ovf when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s8 = 1'b0, bi8 = 1'b0, r8, bs8, d8, bo8;
  logic [7:0] a8 = '0, b8 = '0, df8;
  logic       s4 = 1'b0, bi4 = 1'b0, r4, bs4, d4, bo4;
  logic [3:0] a4 = '0, b4 = '0, df4;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ov8, ov4;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bi8),
    .ready(r8), .busy(bs8), .done(d8), .diff(df8), .bout(bo8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ov8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bi4),
    .ready(r4), .busy(bs4), .done(d4), .diff(df4), .bout(bo4)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ov4)
`endif
  );

  int n_chk = 0, n_fail = 0, dn4 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Integer reference: {signed_overflow, borrow_out, diff zero-extended to 8 bits}
  function automatic logic [9:0] ref_sub(input int w, input int a, input int b, input int bi);
    int r, sa, sb, sr;
    logic [7:0] dd;
    r  = a - b - bi;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sr = sa - sb - bi;
    dd = 8'(r & ((1 << w) - 1));
    return {(sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1), r < 0, dd};
  endfunction

  // Model: phase = cycles since accept (0 = idle); results land when the last bit is done
  int         p8 = 0, p4 = 0;
  logic [9:0] pend8 = '0, pend4 = '0, out8 = '0, out4 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p8 <= 0; out8 <= '0;
    end else if (p8 == 0) begin
      if (s8) begin p8 <= 1; pend8 <= ref_sub(8, a8, b8, bi8); end
    end else begin
      p8 <= (p8 == 9) ? 0 : p8 + 1;
      if (p8 == 8) out8 <= pend8;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p4 <= 0; out4 <= '0;
    end else if (p4 == 0) begin
      if (s4) begin p4 <= 1; pend4 <= ref_sub(4, a4, b4, bi4); end
    end else begin
      p4 <= (p4 == 5) ? 0 : p4 + 1;
      if (p4 == 4) out4 <= pend4;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("ready8", r8, p8 == 0);
    chk("busy8", bs8, p8 >= 1 && p8 <= 8);
    chk("done8", d8, p8 == 9);
    chk("diff8", df8, out8[7:0]);
    chk("bout8", bo8, out8[8]);
    chk("ready4", r4, p4 == 0);
    chk("busy4", bs4, p4 >= 1 && p4 <= 4);
    chk("done4", d4, p4 == 5);
    chk("diff4", df4, out4[3:0]);
    chk("bout4", bo4, out4[8]);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf8", ov8, out8[9]);
    chk("ovf4", ov4, out4[9]);
`endif
    if (d4) dn4++;
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb, input logic eo, input bit noise);
    int k;
    bit seen;
    logic [9:0] m;
    k = 0; seen = 0;
    m = ref_sub(8, a, b, bi);
    chk("model_diff", m[7:0], ed);
    chk("model_bout", m[8], eb);
    chk("model_ovf", m[9], eo);
    @(negedge clk);
    s8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (d8) seen = 1;
      s8  = noise && (k == 3 || k == 8);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      bi8 = 1'($urandom);
    end
    s8 = 1'b0;
    chk("latency", k - 1, 8);
    chk("diff_lit", df8, ed);
    chk("bout_lit", bo8, eb);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_lit", ov8, eo);
`endif
  endtask

  initial begin
    int ghost;
    int k;
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", r8, 1);
    chk("rst_busy", bs8, 0);
    chk("rst_done", d8, 0);
    chk("rst_diff", df8, 0);
    chk("rst_bout", bo8, 0);
    rst_n = 1'b1;

    run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    run8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    run8(8'hA5, 8'h3C, 1'b1, 8'h68, 1'b0, 1'b1, 1'b1);

    // Abort mid-operation: reset while bit 4 is in flight
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h55; b8 = 8'h11; bi8 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      s8 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", r8, 1);
    chk("abort_busy", bs8, 0);
    chk("abort_diff", df8, 0);
    chk("abort_bout", bo8, 0);
    rst_n = 1'b1;
    ghost = 0;
    repeat (12) begin
      @(negedge clk);
      if (d8) ghost++;
    end
    chk("abort_no_done", ghost, 0);
    run8(8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);

    // WIDTH=4 exhaustive back-to-back sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          s4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); bi4 = 1'(ic);
          k = 0; seen = 0;
          while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            s4 = 1'b0;
            if (d4) seen = 1;
          end
          chk("sweep_latency", k, 5);
        end
    repeat (2) @(negedge clk);
    chk("done_count", dn4, 512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
